instruction_fetch: RTL

//  Upstream stage of the control decoder. Reads each 32-bit instruction as two 16-bit

---
 rtl/instruction_fetch_pkg.sv | 29 ++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch state encodings,
// the NOP control word and the default ROM geometry.
package instruction_fetch_pkg;

    // Fetch sequencer states. The state names the phase of the fetch; ROM
    // address/read outputs are loaded on the edge that enters a state, so
    // ADDR_LO and ADDR_HI are the cycles in which romRead is asserted.
    typedef enum logic [1:0] {
        ADDR_LO = 2'd0,
        ADDR_HI = 2'd1,
        CAPT_HI = 2'd2,
        HOLD    = 2'd3
    } fetch_state_e;

    // Control word seen by the decoder whenever no instruction is presented.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Default ROM word-address width and first instruction index.
    localparam int          ROM_AW_DEFAULT   = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Full-width ROM word address of one half of an instruction. Callers
    // truncate the result to their ROM address width, dropping pc MSBs.
    function automatic logic [31:0] rom_word_addr(input logic [15:0] pc,
                                                  input logic        half);
        return {15'd0, pc, half};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads each 32-bit instruction as two 16-bit words
// from a synchronous program ROM, presents the assembled control word with a
// valid/ready handshake, accepts jump redirects and shows NOP while idle.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ROM_AW   = ROM_AW_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,

    output logic [ROM_AW-1:0] romAddr,
    output logic              romRead,
    input  logic [15:0]       romData,

    input  logic              redirect,
    input  logic [15:0]       redirectPc,

    output logic [31:0]       controlWord,
    output logic              wordValid,
    input  logic              wordReady,
    output logic [15:0]       pcOut
);

    fetch_state_e      state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       lo_q, lo_d;
    logic [15:0]       hi_q, hi_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_read_q, rom_read_d;
    logic              word_valid_q, word_valid_d;
    logic [15:0]       pc_out_q, pc_out_d;

    logic              accept;
    logic [ROM_AW-1:0] lo_addr_pc;
    logic [ROM_AW-1:0] hi_addr_pc;
    logic [ROM_AW-1:0] lo_addr_redirect;

    // A transfer happens only when a word is actually on offer.
    assign accept = word_valid_q && wordReady;

    // ROM addresses of both halves at the current pc and of the low half at
    // a redirect target; casting to ROM_AW drops the pc bits the ROM lacks.
    assign lo_addr_pc       = ROM_AW'(rom_word_addr(pc_q, 1'b0));
    assign hi_addr_pc       = ROM_AW'(rom_word_addr(pc_q, 1'b1));
    assign lo_addr_redirect = ROM_AW'(rom_word_addr(redirectPc, 1'b0));

    // Next-state, datapath and registered-output logic for the fetch sequencer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        rom_addr_d   = rom_addr_q;
        rom_read_d   = 1'b0;
        word_valid_d = word_valid_q;
        pc_out_d     = pc_out_q;

        unique case (state_q)
            ADDR_LO: begin
                if (rom_read_q) begin
                    // Low-half read is on the bus; issue the high half next.
                    state_d    = ADDR_HI;
                    rom_addr_d = hi_addr_pc;
                    rom_read_d = 1'b1;
                end else begin
                    // Straight out of reset no read has been issued yet, so
                    // launch the low-half read first and stay here a cycle.
                    rom_addr_d = lo_addr_pc;
                    rom_read_d = 1'b1;
                end
            end

            ADDR_HI: begin
                // Low-half data from the previous read is on romData now.
                lo_d    = romData;
                state_d = CAPT_HI;
            end

            CAPT_HI: begin
                // High-half data arrives; present the complete instruction.
                hi_d         = romData;
                word_valid_d = 1'b1;
                pc_out_d     = pc_q;
                pc_d         = pc_q + 16'd1;
                state_d      = HOLD;
            end

            HOLD: begin
                if (accept) begin
                    // Word consumed: drop back to NOP and start the next fetch.
                    word_valid_d = 1'b0;
                    lo_d         = 16'h0000;
                    hi_d         = 16'h0000;
                    rom_addr_d   = lo_addr_pc;
                    rom_read_d   = 1'b1;
                    state_d      = ADDR_LO;
                end
            end

            default: begin
                state_d = ADDR_LO;
            end
        endcase

        // A redirect overrides everything above: any partial or held word is
        // discarded (an accept in the same cycle still counts as a transfer),
        // data returning for the flushed read is never captured because the
        // low-half capture only happens in ADDR_HI, and the target pc wins
        // over the sequential pc+1.
        if (redirect) begin
            pc_d         = redirectPc;
            lo_d         = 16'h0000;
            hi_d         = 16'h0000;
            word_valid_d = 1'b0;
            pc_out_d     = pc_out_q;
            rom_addr_d   = lo_addr_redirect;
            rom_read_d   = 1'b1;
            state_d      = ADDR_LO;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ADDR_LO;
            pc_q         <= RESET_PC;
            lo_q         <= 16'h0000;
            hi_q         <= 16'h0000;
            rom_addr_q   <= '0;
            rom_read_q   <= 1'b0;
            word_valid_q <= 1'b0;
            pc_out_q     <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            rom_addr_q   <= rom_addr_d;
            rom_read_q   <= rom_read_d;
            word_valid_q <= word_valid_d;
            pc_out_q     <= pc_out_d;
        end
    end

    // The decoder sees opcode 0 whenever no instruction is being presented.
    assign controlWord = word_valid_q ? {hi_q, lo_q} : NOP_WORD;
    assign wordValid   = word_valid_q;
    assign pcOut       = pc_out_q;
    assign romAddr     = rom_addr_q;
    assign romRead     = rom_read_q;

endmodule
